seq_det_ctrl: RTL
=================

# seq_det_ctrl

Programmable serial pattern-detection controller for the FSM library. It accepts a PW-bit pattern and a match target over a valid/ready config handshake. On `start` it scans a qualified serial bit stream in either overlapping or non-overlapping mode, counts matches and signals completion. It generalises the fixed 4-bit 1010 detectors into a reusable, host-configured block sitting between a serial input shifter and a status/interrupt register.

## Interface
- PW, 4: pattern width in bits, PW >= 2; bit PW-1 is the first bit received.
- CW, 8: match counter and target width.

- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept; high in IDLE, ARMED and DONE, low in RUN.
- cfg_pattern  in  PW  pattern to detect; sampled on handshake.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on handshake.
- cfg_target  in  CW  matches to reach DONE; 0 = unlimited; sampled on handshake.
- start  in  1  begin a scan (ARMED/DONE only).
- abort  in  1  stop a scan (RUN only).
- in_valid  in  1  qualifies `in`.
- in  in  1  serial data bit.
- match  out  1  one-cycle pulse per detected pattern (registered).
- count  out  CW  matches since last start.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

## Operation
- States: IDLE, ARMED, RUN, DONE (2-bit encoding; illegal encodings go to IDLE).
- IDLE:
  - cfg_valid → latch pattern, overlap and target; go to ARMED.
  - start is ignored.
- ARMED:
  - cfg_valid → reload config; stay in ARMED.
  - start (with no config accepted in the same cycle) → RUN. This clears count, the history shift register `hist[PW-1:0]` and the fill counter.
- RUN:
  - On each `in_valid`, `nxt = {hist[PW-2:0], in}` is loaded into hist.
  - fill increments and saturates at PW; fill width is clog2(PW+1).
  - A hit occurs when `in_valid`, `nxt == pattern` and `fill + 1 >= PW` (i.e. `fill >= PW-1`).
  - On a hit:
    - match is 1 on the next cycle.
    - count increments.
    - Overlap = 1 keeps hist and fill.
    - Overlap = 0 resets fill to 0, so the bits of a match are never reused.
  - If target != 0 and the incremented count == target → DONE on the same edge.
  - With target == 0, count saturates at 2^CW-1 and match keeps pulsing.
  - If `in_valid` = 0, hist, fill and count are held.
  - abort → ARMED; count is held, and any hit in that same cycle is discarded (abort has priority).
- DONE:
  - start → RUN, which clears count as in ARMED.
  - cfg_valid → reload config and go to ARMED.
  - If both are asserted, config wins and start is ignored.
  - count is held.
- `in`/`in_valid` are ignored outside RUN. abort is ignored outside RUN.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, so cfg_ready = 1, match = 0, count = 0, busy = 0, done = 0; hist, fill and config regs = 0.
- cfg_ready, busy and done decode directly from state; they change the edge after the causing event.
- Match latency: the bit completing a pattern is sampled on edge N. On edge N:
  - match rises and count updates.
  - done rises on the final target match.
  - match falls on edge N+1 unless another hit occurs.
- The first possible match is on the PW-th valid bit after start.
- Back-to-back hits (overlap) produce consecutive match-high cycles.
- Reset mid-RUN aborts immediately; no match pulse follows.

## Test plan
- **Overlap:** config pattern 4'b1010, overlap = 1, target = 0; start; stream 1,0,1,0,1,0 with in_valid = 1 → match pulses after bits 4 and 6; count = 2; busy stays 1.
- **Non-overlap:** same config with overlap = 0 and the same stream → one match after bit 4; count = 1. Continuing with 1,0 → second match after bit 8.
- **Target/DONE:** pattern 4'b1111, target = 2, overlap = 1; stream of five 1s → matches after bits 4 and 5; done = 1 and busy = 0 the cycle match rises for the second hit; bit 6 is ignored; count = 2.
- **Gaps and abort:** stream 1,0,1 with in_valid gaps of 3 idle cycles, then abort asserted together with a completing 0 → no match; state ARMED; count = 0.
- **Config priority:** in DONE, assert cfg_valid and start together → ARMED with new config; count unchanged; busy = 0.
- **Reset mid-run:** drop rstn during RUN after 3 valid bits → all outputs at reset values asynchronously. After release, IDLE with cfg_ready = 1; start alone has no effect.

Source files
------------

// File: rtl/seq_det_ctrl_if.sv
// Handshake/stream bundle for seq_det_ctrl.
//   cfg_*        : config offer (valid/ready) with pattern, overlap mode, target
//   start/abort  : scan control
//   in_valid/in  : qualified serial bit stream
//   match/count/busy/done : status back to the host
// master = host/bench side, slave = controller side.
interface seq_det_ctrl_if #(
  parameter int PW = 4,
  parameter int CW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_pattern;
  logic          cfg_overlap;
  logic [CW-1:0] cfg_target;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in;
  logic          match;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_overlap, cfg_target,
    output start, abort, in_valid, in,
    input  cfg_ready, match, count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_overlap, cfg_target,
    input  start, abort, in_valid, in,
    output cfg_ready, match, count, busy, done
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector with a host config handshake.
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : seq_det_ctrl_if.slave (config, start/abort, serial input, status)
// A PW-bit pattern (MSB = first bit received) is matched against a shift
// history of qualified input bits. Overlapping mode keeps the history after
// a hit; non-overlapping mode restarts the fill count so no bit is reused.
module seq_det_ctrl #(
  parameter int PW = 4,
  parameter int CW = 8
) (
  input logic           clk,
  input logic           rstn,
  seq_det_ctrl_if.slave bus
);
  localparam int FW = $clog2(PW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PW-1:0] pattern;
    logic          overlap;
    logic [CW-1:0] target;
  } cfg_t;

  state_t        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [PW-1:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match_q, match_d;

  cfg_t          cfg_in;
  logic [PW-1:0] nxt;
  logic [FW-1:0] fill_inc;
  logic [CW-1:0] cnt_inc;
  logic          hit;

  assign cfg_in   = '{pattern: bus.cfg_pattern, overlap: bus.cfg_overlap,
                      target: bus.cfg_target};
  assign nxt      = {hist_q[PW-2:0], bus.in};
  assign fill_inc = (fill_q == FW'(PW)) ? fill_q : fill_q + FW'(1);
  // Saturating increment covers the unlimited-target case; with a nonzero
  // target the count never gets past the target anyway.
  assign cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  // fill counts bits already in history, so the incoming bit completes
  // a full window once fill reaches PW-1.
  assign hit      = bus.in_valid && (nxt == cfg_q.pattern) &&
                    (fill_q >= FW'(PW - 1));

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          cfg_d   = cfg_in;
          state_d = ARMED;
        end
      end
      ARMED, DONE: begin
        // Config accept has priority over start in both states.
        if (bus.cfg_valid) begin
          cfg_d   = cfg_in;
          state_d = ARMED;
        end else if (bus.start) begin
          cnt_d   = '0;
          hist_d  = '0;
          fill_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = ARMED;
        end else if (bus.in_valid) begin
          hist_d = nxt;
          fill_d = fill_inc;
          if (hit) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc;
            if (!cfg_q.overlap) fill_d = '0;
            if (cfg_q.target != '0 && cnt_inc == cfg_q.target) state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign bus.cfg_ready = (state_q != RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.match     = match_q;
  assign bus.count     = cnt_q;
endmodule
